// File: rtl/fb_swap_ctrl.sv
// Double-buffer sequencer: routes pixel writes to the back buffer, flips on frame end, clears, then acks.
// Latency: processor write at t reaches the buffer port at t+1; all outputs registered.
// No backpressure: writes outside DRAW or out of range are dropped and flagged on sticky wr_err.
module fb_swap_ctrl #(
    parameter int                ADDR_W      = 17,
    parameter int                DATA_W      = 16,
    parameter int                PIXELS      = 76800,
    parameter bit                CLEAR_EN    = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              bb_we,
    input  logic [31:0]       waddr,
    input  logic [31:0]       din,
    input  logic              done,
    input  logic              frame_end,
    output logic              swap,
    output logic              front_sel,
    output logic              buf0_we,
    output logic              buf1_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              wr_err
);
    typedef enum logic [1:0] {DRAW, WAIT_VS, CLEAR, ACK} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] cnt, cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              front_d, we_d, err_d, in_range;
    logic              unused_din;

    assign in_range   = waddr < 32'(PIXELS);
    assign unused_din = ^din;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        front_d = front_sel;
        we_d    = 1'b0;
        addr_d  = wr_addr;
        data_d  = wr_data;
        err_d   = wr_err;
        if (bb_we && (state != DRAW || !in_range))
            err_d = 1'b1;
        case (state)
            DRAW: begin
                if (bb_we && in_range) begin
                    we_d   = 1'b1;
                    addr_d = waddr[ADDR_W-1:0];
                    data_d = din[DATA_W-1:0];
                end
                if (done)
                    state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (frame_end) begin
                    front_d = ~front_sel;
                    cnt_d   = '0;
                    if (CLEAR_EN) begin
                        // First clear write leaves on the flip edge so clearing starts at f+1.
                        state_d = CLEAR;
                        we_d    = 1'b1;
                        addr_d  = '0;
                        data_d  = CLEAR_COLOR;
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            CLEAR: begin
                // cnt holds the address currently on the port.
                if (cnt == LAST_ADDR) begin
                    state_d = ACK;
                end else begin
                    cnt_d  = cnt + ADDR_W'(1);
                    we_d   = 1'b1;
                    addr_d = cnt + ADDR_W'(1);
                    data_d = CLEAR_COLOR;
                end
            end
            ACK: begin
                if (!done)
                    state_d = DRAW;
            end
            default: state_d = DRAW;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state     <= DRAW;
            cnt       <= '0;
            front_sel <= 1'b0;
            swap      <= 1'b0;
            buf0_we   <= 1'b0;
            buf1_we   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            front_sel <= front_d;
            swap      <= (state_d == ACK);
            buf0_we   <= we_d & front_d;
            buf1_we   <= we_d & ~front_d;
            wr_addr   <= addr_d;
            wr_data   <= data_d;
            busy      <= (state_d != DRAW);
            wr_err    <= err_d;
        end
    end
endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: two instances (clear on / clear off) on shared stimulus, checked against a phase/cycle model.
module tb_fb_swap_ctrl;
    localparam int PIX = 16;
    localparam logic [15:0] CC = 16'h00AA;

    logic        clk = 1'b0;
    logic        rst_n, bb_we, done, frame_end;
    logic [31:0] waddr, din;

    logic       swap0, front0, we00, we10, busy0, err0;
    logic [4:0] addr0;
    logic [15:0] data0;
    logic       swap1, front1, we01, we11, busy1, err1;
    logic [4:0] addr1;
    logic [15:0] data1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mvalid = 1'b0;

    always #5 clk = ~clk;

    fb_swap_ctrl #(.ADDR_W(5), .DATA_W(16), .PIXELS(PIX), .CLEAR_EN(1'b1), .CLEAR_COLOR(CC)) u0 (
        .clk_clk(clk), .reset_reset_n(rst_n), .bb_we(bb_we), .waddr(waddr), .din(din),
        .done(done), .frame_end(frame_end), .swap(swap0), .front_sel(front0),
        .buf0_we(we00), .buf1_we(we10), .wr_addr(addr0), .wr_data(data0),
        .busy(busy0), .wr_err(err0));

    fb_swap_ctrl #(.ADDR_W(5), .DATA_W(16), .PIXELS(PIX), .CLEAR_EN(1'b0), .CLEAR_COLOR(CC)) u1 (
        .clk_clk(clk), .reset_reset_n(rst_n), .bb_we(bb_we), .waddr(waddr), .din(din),
        .done(done), .frame_end(frame_end), .swap(swap1), .front_sel(front1),
        .buf0_we(we01), .buf1_we(we11), .wr_addr(addr1), .wr_data(data1),
        .busy(busy1), .wr_err(err1));

    // phase: 0 drawing, 1 waiting for vsync, 2 clearing, 3 acknowledging
    typedef struct {
        int         phase;
        bit         front;
        bit         err;
        int         fe;
        bit         we0;
        bit         we1;
        logic [4:0] addr;
        logic [15:0] data;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t step(input mdl_t s, input bit clr_en, input int c);
        mdl_t n = s;
        n.we0 = 1'b0;
        n.we1 = 1'b0;
        if (!rst_n) begin
            n.phase = 0; n.front = 1'b0; n.err = 1'b0; n.addr = '0; n.data = '0;
            return n;
        end
        case (s.phase)
            0: begin
                if (bb_we) begin
                    if (waddr < PIX) begin
                        if (s.front) n.we0 = 1'b1; else n.we1 = 1'b1;
                        n.addr = waddr[4:0];
                        n.data = din[15:0];
                    end else n.err = 1'b1;
                end
                if (done) n.phase = 1;
            end
            1: begin
                if (bb_we) n.err = 1'b1;
                if (frame_end) begin
                    n.front = !s.front;
                    n.fe    = c;
                    n.phase = clr_en ? 2 : 3;
                end
            end
            2: if (bb_we) n.err = 1'b1;
            default: begin
                if (bb_we) n.err = 1'b1;
                if (!done) n.phase = 0;
            end
        endcase
        // Clear write k (0..PIX-1) is issued k edges after the flip edge.
        if (n.phase == 2) begin
            if (c - n.fe < PIX) begin
                if (n.front) n.we0 = 1'b1; else n.we1 = 1'b1;
                n.addr = 5'(c - n.fe);
                n.data = CC;
            end else n.phase = 3;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m0     <= step(m0, 1'b1, cyc);
        m1     <= step(m1, 1'b0, cyc);
        cyc    <= cyc + 1;
        mvalid <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_inst(input string tag, input mdl_t e, input logic sw, input logic bz,
                            input logic fr, input logic er, input logic w0, input logic w1,
                            input logic [4:0] a, input logic [15:0] d);
        chk({tag, ".swap"}, 32'(sw), 32'(e.phase == 3));
        chk({tag, ".busy"}, 32'(bz), 32'(e.phase != 0));
        chk({tag, ".front_sel"}, 32'(fr), 32'(e.front));
        chk({tag, ".wr_err"}, 32'(er), 32'(e.err));
        chk({tag, ".buf0_we"}, 32'(w0), 32'(e.we0));
        chk({tag, ".buf1_we"}, 32'(w1), 32'(e.we1));
        if (e.we0 || e.we1) begin
            chk({tag, ".wr_addr"}, 32'(a), 32'(e.addr));
            chk({tag, ".wr_data"}, 32'(d), 32'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            cmp_inst("u0", m0, swap0, busy0, front0, err0, we00, we10, addr0, data0);
            cmp_inst("u1", m1, swap1, busy1, front1, err1, we01, we11, addr1, data1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " front_sel"}, 32'(front0), 0);
        chk({tag, " swap"}, 32'(swap0), 0);
        chk({tag, " busy"}, 32'(busy0), 0);
        chk({tag, " wr_err"}, 32'(err0), 0);
        chk({tag, " we"}, 32'({we00, we10}), 0);
        chk({tag, " wr_addr"}, 32'(addr0), 0);
        chk({tag, " wr_data"}, 32'(data0), 0);
    endtask

    initial begin
        rst_n = 1'b0; bb_we = 1'b0; done = 1'b0; frame_end = 1'b0; waddr = '0; din = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk_reset_outputs("reset");

        // Basic write lands on buf1 one cycle later.
        bb_we = 1'b1; waddr = 3; din = 32'h1234;
        tick();
        bb_we = 1'b0;
        chk("wr buf1_we", 32'(we10), 1);
        chk("wr buf0_we", 32'(we00), 0);
        chk("wr addr", 32'(addr0), 3);
        chk("wr data", 32'(data0), 32'h1234);

        // Out of range write sets sticky error.
        bb_we = 1'b1; waddr = 16; din = 32'h5555;
        tick();
        chk("oor we", 32'({we00, we10}), 0);
        chk("oor err", 32'(err0), 1);
        waddr = 4;
        tick();
        bb_we = 1'b0;
        chk("oor then valid we", 32'(we10), 1);
        chk("oor err sticky", 32'(err0), 1);

        // Full swap with clear.
        done = 1'b1;
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("swap front f+1", 32'(front0), 1);
        chk("noclr swap f+1", 32'(swap1), 1);
        chk("noclr no we", 32'({we01, we11}), 0);
        for (int i = 0; i < PIX; i++) begin
            chk("clr buf0_we", 32'(we00), 1);
            chk("clr buf1_we", 32'(we10), 0);
            chk("clr addr", 32'(addr0), 32'(i));
            chk("clr data", 32'(data0), 32'(CC));
            chk("clr no swap", 32'(swap0), 0);
            tick();
        end
        chk("swap f+17", 32'(swap0), 1);
        chk("post clr we", 32'(we00), 0);
        done = 1'b0;
        tick();
        chk("swap drop", 32'(swap0), 0);
        chk("busy drop", 32'(busy0), 0);
        bb_we = 1'b1; waddr = 5; din = 32'h77;
        tick();
        bb_we = 1'b0;
        chk("after swap buf0_we", 32'(we00), 1);
        chk("after swap addr", 32'(addr0), 5);

        // Early frame_end: before done, and together with done.
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("early fe front", 32'(front0), 1);
        done = 1'b1; frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("fe+done front", 32'(front0), 1);
        chk("fe+done busy", 32'(busy0), 1);
        tick(); tick(); tick();
        chk("waiting front", 32'(front0), 1);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("second flip front", 32'(front0), 0);
        repeat (PIX) tick();
        chk("second swap", 32'(swap0), 1);
        done = 1'b0;
        tick();
        chk("second swap drop", 32'(swap0), 0);

        // Reset in the middle of a clear.
        done = 1'b1;
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        repeat (4) tick();
        chk("abort clr addr", 32'(addr0), 4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; done = 1'b0;
        chk_reset_outputs("abort");
        tick();

        // Write during WAIT_VS is dropped.
        done = 1'b1;
        tick();
        done = 1'b0; bb_we = 1'b1; waddr = 2; din = 32'h99;
        tick();
        bb_we = 1'b0;
        chk("wait drop we", 32'({we00, we10}), 0);
        chk("wait drop err", 32'(err0), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            bb_we     = ($urandom_range(0, 1) == 1);
            waddr     = 32'($urandom_range(0, 19));
            din       = $urandom;
            frame_end = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) done = ~done;
            rst_n     = ($urandom_range(0, 299) != 0);
            tick();
        end
        bb_we = 1'b0; frame_end = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
